// File: rtl/ps2_kbd_pkg.sv
// Shared types and byte constants for the PS/2 keyboard sequencer.
// Optional build macro used by ps2_kbd_ctrl: PS2_TYPEMATIC_FILTER_EN.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPop    = 2'd1,
        StDecode = 2'd2
    } kbd_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

endpackage

// File: rtl/ps2_scan_classify.sv
// Combinational classifier: sorts one scan byte into prefix, protocol-drop and error classes.
module ps2_scan_classify
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_ext,
    output logic       is_brk,
    output logic       is_drop,
    output logic       is_err
);

    always_comb begin
        is_ext  = (data == PS2_EXT);
        is_brk  = (data == PS2_BRK);
        is_err  = (data == PS2_ERR0) || (data == PS2_ERR1);
        // Error bytes are also dropped; is_err only adds the sticky flag.
        is_drop = is_err || (data == PS2_PAUSE) || (data == PS2_BAT) ||
                  (data == PS2_ACK) || (data == PS2_RESEND);
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: pops receiver FIFO, folds E0/F0 prefixes into key events.
// Build macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic             ev_valid,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             key_held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] make_count,
    output logic             err_sticky
);

    kbd_state_t       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic             ev_valid_q, ev_valid_d;
    logic [7:0]       ev_code_q, ev_code_d;
    logic             ev_ext_q, ev_ext_d;
    logic             ev_break_q, ev_break_d;
    logic             key_held_q, key_held_d;
    logic [8:0]       held_code_q, held_code_d;
    logic [CNT_W-1:0] make_count_q, make_count_d;
    logic             err_q, err_d;

    logic       is_ext, is_brk, is_drop, is_err;
    logic [8:0] key;
    logic       repeat_make;

    ps2_scan_classify u_classify (
        .data    (byte_q),
        .is_ext  (is_ext),
        .is_brk  (is_brk),
        .is_drop (is_drop),
        .is_err  (is_err)
    );

    assign key = {ext_pend_q, byte_q};

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign repeat_make = key_held_q && (key == held_code_q);
`else
    assign repeat_make = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_n_d = 1'b1;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        ev_valid_d   = 1'b0;
        ev_code_d    = ev_code_q;
        ev_ext_d     = ev_ext_q;
        ev_break_d   = ev_break_q;
        key_held_d   = key_held_q;
        held_code_d  = held_code_q;
        make_count_d = make_count_q;
        err_d        = err_q | kbd_overflow;

        case (state_q)
            StIdle: begin
                if (kbd_ready) begin
                    byte_d       = kbd_data;
                    nextdata_n_d = 1'b0;
                    state_d      = StPop;
                end
            end
            StPop: begin
                state_d = StDecode;
            end
            StDecode: begin
                state_d = StIdle;
                if (is_ext) begin
                    ext_pend_d = 1'b1;
                end else if (is_brk) begin
                    brk_pend_d = 1'b1;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (is_err) begin
                        err_d = 1'b1;
                    end
                    if (!is_drop) begin
                        if (brk_pend_q) begin
                            ev_valid_d = 1'b1;
                            ev_code_d  = byte_q;
                            ev_ext_d   = ext_pend_q;
                            ev_break_d = 1'b1;
                            if (key == held_code_q) begin
                                key_held_d = 1'b0;
                            end
                        end else if (!repeat_make) begin
                            ev_valid_d   = 1'b1;
                            ev_code_d    = byte_q;
                            ev_ext_d     = ext_pend_q;
                            ev_break_d   = 1'b0;
                            key_held_d   = 1'b1;
                            held_code_d  = key;
                            make_count_d = make_count_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= StIdle;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= 8'h00;
            ev_ext_q     <= 1'b0;
            ev_break_q   <= 1'b0;
            key_held_q   <= 1'b0;
            held_code_q  <= 9'h000;
            make_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            ev_valid_q   <= ev_valid_d;
            ev_code_q    <= ev_code_d;
            ev_ext_q     <= ev_ext_d;
            ev_break_q   <= ev_break_d;
            key_held_q   <= key_held_d;
            held_code_q  <= held_code_d;
            make_count_q <= make_count_d;
            err_q        <= err_d;
        end
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign ev_valid       = ev_valid_q;
    assign ev_code        = ev_code_q;
    assign ev_ext         = ev_ext_q;
    assign ev_break       = ev_break_q;
    assign key_held       = key_held_q;
    assign held_code      = held_code_q;
    assign make_count     = make_count_q;
    assign err_sticky     = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: models the receiver FIFO and checks each emitted event.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic       kbd_nextdata_n;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       key_held;
    logic [8:0] held_code;
    logic [7:0] make_count;
    logic       err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo[$];
    logic [9:0] sb[$];  // {brk, ext, code}

    bit mon_hs = 0;
    int cyc = 0;
    int last_pop = 0;
    int pop_cnt = 0;
    logic prev_nd = 1'b1;

    ps2_kbd_ctrl #(.CNT_W(8)) dut (
        .clk            (clk),
        .clr            (clr),
        .kbd_data       (kbd_data),
        .kbd_ready      (kbd_ready),
        .kbd_overflow   (kbd_overflow),
        .kbd_nextdata_n (kbd_nextdata_n),
        .ev_valid       (ev_valid),
        .ev_code        (ev_code),
        .ev_ext         (ev_ext),
        .ev_break       (ev_break),
        .key_held       (key_held),
        .held_code      (held_code),
        .make_count     (make_count),
        .err_sticky     (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void upd_fifo();
        kbd_ready = (fifo.size() != 0);
        kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endfunction

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) fifo.push_back(b[i]);
        upd_fifo();
    endtask

    task automatic exp_ev(input logic [7:0] code, input logic ext, input logic brk);
        sb.push_back({brk, ext, code});
    endtask

    task automatic drain();
        int n = 0;
        while (fifo.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check("drain", fifo.size(), 0);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    // Receiver FIFO pops while the strobe is low; events go to the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!kbd_nextdata_n) begin
            if (mon_hs) begin
                check("nd_pulse_width", prev_nd, 1);
                if (pop_cnt > 0) check("pop_gap", cyc - last_pop, 3);
                last_pop = cyc;
                pop_cnt++;
            end
            if (fifo.size() != 0) void'(fifo.pop_front());
            upd_fifo();
        end
        prev_nd = kbd_nextdata_n;
        if (ev_valid) begin
            if (sb.size() == 0) begin
                check("ev_unexpected", ev_valid, 0);
            end else begin
                check("ev", {ev_break, ev_ext, ev_code}, sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_nd", kbd_nextdata_n, 1);
        check("rst_ev", {ev_valid, ev_break, ev_ext, ev_code}, 0);
        check("rst_held", {key_held, held_code}, 0);
        check("rst_cnt", make_count, 0);
        check("rst_err", err_sticky, 0);

        // 1: single make
        exp_ev(8'h1C, 0, 0);
        push_bytes('{8'h1C});
        drain();
        check("t1_held", key_held, 1);
        check("t1_code", held_code, 9'h01C);
        check("t1_cnt", make_count, 1);

        // 2: make then break
        do_reset();
        exp_ev(8'h1C, 0, 0);
        exp_ev(8'h1C, 0, 1);
        push_bytes('{8'h1C, 8'hF0, 8'h1C});
        drain();
        check("t2_held", key_held, 0);
        check("t2_code", held_code, 9'h01C);
        check("t2_cnt", make_count, 1);

        // 3: extended make and break
        do_reset();
        exp_ev(8'h75, 1, 0);
        exp_ev(8'h75, 1, 1);
        push_bytes('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
        drain();
        check("t3_held", key_held, 0);
        check("t3_code", held_code, 9'h175);
        check("t3_cnt", make_count, 1);

        // 4: typematic repeat
        do_reset();
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_ev(8'h1C, 0, 0);
        push_bytes('{8'h1C, 8'h1C, 8'h1C});
        drain();
        check("t4_cnt", make_count, 1);
`else
        exp_ev(8'h1C, 0, 0);
        exp_ev(8'h1C, 0, 0);
        exp_ev(8'h1C, 0, 0);
        push_bytes('{8'h1C, 8'h1C, 8'h1C});
        drain();
        check("t4_cnt", make_count, 3);
`endif
        check("t4_held", {key_held, held_code}, 10'h21C);

        // 5: handshake timing with ready held high for four bytes
        do_reset();
        exp_ev(8'h15, 0, 0);
        exp_ev(8'h16, 0, 0);
        exp_ev(8'h17, 0, 0);
        exp_ev(8'h18, 0, 0);
        mon_hs = 1;
        pop_cnt = 0;
        push_bytes('{8'h15, 8'h16, 8'h17, 8'h18});
        drain();
        check("t5_pops", pop_cnt, 4);
        repeat (10) @(negedge clk);
        check("t5_idle_pops", pop_cnt, 4);
        mon_hs = 0;
        check("t5_cnt", make_count, 4);

        // 6: protocol/error bytes, overflow, clear during pop
        do_reset();
        push_bytes('{8'hAA, 8'hFA, 8'h00});
        drain();
        check("t6_err_byte", err_sticky, 1);
        check("t6_cnt", make_count, 0);
        do_reset();
        @(negedge clk);
        check("t6_err_clr", err_sticky, 0);
        kbd_overflow = 1'b1;
        @(negedge clk);
        kbd_overflow = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_ovf", err_sticky, 1);

        exp_ev(8'h1C, 0, 0);
        push_bytes('{8'h1C});
        drain();
        push_bytes('{8'h2C});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!kbd_nextdata_n) break;
        end
        check("t6_in_pop", kbd_nextdata_n, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t6_clr_nd", kbd_nextdata_n, 1);
        check("t6_clr_ev", {ev_valid, ev_break, ev_ext, ev_code}, 0);
        check("t6_clr_held", {key_held, held_code}, 0);
        check("t6_clr_cnt", make_count, 0);
        check("t6_clr_err", err_sticky, 0);
        repeat (8) @(negedge clk);
        check("t6_lost_byte", make_count, 0);
        check("t6_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
